// File: rtl/divider.sv
// rtl/divider.sv - Restoring unsigned divider producing one quotient bit per clock.
// A zero divisor skips the iteration and reports all-ones quotient with div_by_zero set.
module divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [WIDTH:0] R_ONE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             zero_div;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;

    assign zero_div = (divisor == '0);
    assign r_shift  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    // Subtraction as add-complement; the extra top bit is the borrow that decides restore.
    assign trial    = r_shift + ~{1'b0, dsr_q} + R_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        q_d    = q_q;
        r_d    = r_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
        dbz_d  = dbz_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dsr_d = divisor;
                    if (zero_div) begin
                        q_d    = '1;
                        r_d    = {1'b0, dividend};
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        q_d   = dividend;
                        r_d   = '0;
                        cnt_d = '0;
                        dbz_d = 1'b0;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_ONE;
                if (trial[WIDTH]) begin
                    r_d = r_shift;
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end else begin
                    r_d = trial;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end
                if (cnt_q == LAST_STEP) begin
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = done_q;
        div_by_zero = dbz_q;
        quotient    = q_q;
        remainder   = r_q[WIDTH-1:0];
    end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, which is the operand and result width in bits.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit, SHALL be the reset: asynchronous, active-low (0 = reset asserted).
REQ-004 Port start, input, 1 bit, SHALL request a division and is sampled only in IDLE.
REQ-005 Port dividend, input, WIDTH bits, SHALL be the unsigned dividend, captured on the accepting edge.
REQ-006 Port divisor, input, WIDTH bits, SHALL be the unsigned divisor, captured on the accepting edge.
REQ-007 Port quotient, output, WIDTH bits, SHALL be the registered quotient.
REQ-008 Port remainder, output, WIDTH bits, SHALL be the registered remainder.
REQ-009 Port busy, output, 1 bit, SHALL be high in CALC and DONE.
REQ-010 Port done, output, 1 bit, SHALL be a registered one-cycle pulse: results valid.
REQ-011 Port div_by_zero, output, 1 bit, SHALL be registered and high when the last accepted operation had divisor == 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 IDLE + start=1 + divisor!=0: on that edge, capture the divisor, load Q=dividend, clear the partial remainder R (WIDTH+1 bits), clear the iteration counter, clear div_by_zero, and go to CALC.
REQ-014 IDLE + start=1 + divisor==0: on that edge, set quotient to all ones, set remainder to dividend, set div_by_zero=1, and go directly to DONE (skip CALC).
REQ-015 IDLE + start=0: the state SHALL remain IDLE and all outputs hold.
REQ-016 Each CALC edge SHALL perform one restoring step.
- Shift: R' = {R[WIDTH-1:0], Q[WIDTH-1]}; Q shifts left.
- Trial: T = R' - divisor, formed as R' + ~{0,divisor} + 1 (WIDTH+1 bits).
- If T[WIDTH]==0: R=T and Q[0]=1.
- Otherwise: R=R' and Q[0]=0.
REQ-017 The counter SHALL increment each CALC edge; on the WIDTH-th CALC edge the FSM SHALL go to DONE and set done=1.
REQ-018 Latency SHALL be as follows.
- Non-zero divisor: done high in the cycle after the (WIDTH+1)-th rising edge counted from, and including, the accepting edge.
- Zero divisor: done high in the cycle after the accepting edge.
REQ-019 DONE SHALL last exactly one cycle and then return unconditionally to IDLE; start is ignored in DONE.
REQ-020 start SHALL be ignored in CALC; captured operands SHALL not change until the next acceptance.
REQ-021 quotient = Q and remainder = R[WIDTH-1:0] SHALL hold their values from DONE until the next accepting edge.
REQ-022 For divisor != 0, results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor.
REQ-023 Back-to-back: start held high SHALL be accepted again in the IDLE cycle following DONE (minimum spacing WIDTH+2 cycles).

Reset
REQ-024 reset=0 SHALL immediately set state=IDLE, quotient=0, remainder=0, counter=0, busy=0, done=0 and div_by_zero=0, regardless of clk.
REQ-025 Reset asserted mid-CALC SHALL abandon the operation with no done pulse; after release the block SHALL await a new start.
REQ-026 No start SHALL be accepted on an edge where reset is low.

Verification
REQ-027 The bench SHALL check: dividend=100, divisor=7 -> quotient=14, remainder=2, div_by_zero=0, done one cycle after 9 edges from acceptance.
REQ-028 The bench SHALL check: dividend=255, divisor=1 -> quotient=255, remainder=0; and dividend=3, divisor=200 -> quotient=0, remainder=3.
REQ-029 The bench SHALL check: dividend=5, divisor=0 -> quotient=255, remainder=5, div_by_zero=1, done pulse one cycle after acceptance.
REQ-030 The bench SHALL check that start pulsed with 50/5 during CALC of 100/7 is ignored -> result 14 r 2, then busy=0, and no second done.
REQ-031 The bench SHALL check that reset low at CALC step 4 of 200/9 -> all outputs 0 and no done; a new 200/9 after release -> quotient=22, remainder=2.
REQ-032 The bench SHALL run an exhaustive WIDTH=8 sweep (all dividend and divisor pairs, divisor!=0) checked against a reference model per REQ-022.
